degamma_correction: RTL and testbench

DEGAMMA_CORRECTION -- requirements
Module: degamma_correction

---
 rtl/hdr_pkg.sv | 8 +
 rtl/delay_rg.sv | 23 ++
 rtl/gamma_lut_ram.sv | 23 ++
 rtl/degamma_correction.sv | 86 ++++++++
 tb/tb_degamma_correction.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hdr_pkg.sv
// hdr_pkg: shared widths, LUT geometry and lookup state encoding for the degamma path
package hdr_pkg;
   localparam int HDR_DW_IN     = 8;
   localparam int HDR_DW_OUT    = 12;
   localparam int HDR_LUT_DEPTH = 256;
   localparam int HDR_LUT_AW    = $clog2(HDR_LUT_DEPTH);
   typedef enum logic [1:0] {BYPASS, ACTIVE, PENDING} lut_state_e;
endpackage

// File: rtl/delay_rg.sv
// delay_rg: D-stage register delay of a W-bit bus, cleared by sync reset
//   clk_i, rst_i : clock, active-high synchronous reset
//   d_i / q_o    : bus in, bus delayed by D clocks
module delay_rg #(
   parameter int W = 3,
   parameter int D = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] sr_q [D];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < D; k++) sr_q[k] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
      end
   end
   assign q_o = sr_q[D-1];
endmodule

// File: rtl/gamma_lut_ram.sv
// gamma_lut_ram: 2^AW x DW RAM, one write port, one registered read port
//   clk_i                      : clock
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_addr_i / rd_data_o       : read address, data one clock later
module gamma_lut_ram #(
   parameter int AW = 9,
   parameter int DW = 12
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);
   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rd_data_q;
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_q <= mem_q[rd_addr_i];
   end
   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/degamma_correction.sv
// degamma_correction: 2-pixel/beat gamma-to-linear conversion via double-banked LUT, 2-clock latency
//   clk, reset                        : clock, active-high synchronous reset
//   raw_data_0/1 + valid/sop/eop      : gamma-encoded input beat
//   lut_wr_en/addr/data, lut_commit   : shadow-bank load and swap request
//   lin_data_0/1 + valid/sop/eop      : linearised output beat
//   lut_pending, lut_active_bank      : swap status
module degamma_correction
   import hdr_pkg::*;
#(
   parameter int DW_IN  = HDR_DW_IN,
   parameter int DW_OUT = HDR_DW_OUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DW_IN-1:0]      raw_data_0,
   input  logic [DW_IN-1:0]      raw_data_1,
   input  logic                  raw_data_valid,
   input  logic                  raw_data_sop,
   input  logic                  raw_data_eop,
   input  logic                  lut_wr_en,
   input  logic [HDR_LUT_AW-1:0] lut_wr_addr,
   input  logic [DW_OUT-1:0]     lut_wr_data,
   input  logic                  lut_commit,
   output logic [DW_OUT-1:0]     lin_data_0,
   output logic [DW_OUT-1:0]     lin_data_1,
   output logic                  lin_data_valid,
   output logic                  lin_data_sop,
   output logic                  lin_data_eop,
   output logic                  lut_pending,
   output logic                  lut_active_bank
);
   lut_state_e        state_q, state_d;
   logic              bank_q, bank_d;
   logic              lut_on_q, lut_on_d;
   logic              swap, rd_bank, wr_en;
   logic              use_lut_q;
   logic [DW_IN-1:0]  raw0_q, raw1_q;
   logic [DW_OUT-1:0] lut0, lut1, lin0_q, lin1_q;
   always_comb begin
      swap     = (state_q == PENDING) && raw_data_valid && raw_data_sop;
      bank_d   = bank_q ^ swap;
      lut_on_d = lut_on_q | swap;
      state_d  = state_q;
      if (swap) state_d = ACTIVE;
      else if (lut_commit && state_q != PENDING) state_d = PENDING;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= BYPASS;
         bank_q   <= 1'b0;
         lut_on_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         lut_on_q <= lut_on_d;
      end
   end
   // the swapping sop beat already reads from the new bank
   assign rd_bank = bank_q ^ swap;
   assign wr_en   = lut_wr_en && state_q != PENDING;
   gamma_lut_ram #(.AW(HDR_LUT_AW + 1), .DW(DW_OUT)) u_lut0 (
      .clk_i(clk), .wr_en_i(wr_en), .wr_addr_i({~bank_q, lut_wr_addr}), .wr_data_i(lut_wr_data),
      .rd_addr_i({rd_bank, raw_data_0}), .rd_data_o(lut0)
   );
   gamma_lut_ram #(.AW(HDR_LUT_AW + 1), .DW(DW_OUT)) u_lut1 (
      .clk_i(clk), .wr_en_i(wr_en), .wr_addr_i({~bank_q, lut_wr_addr}), .wr_data_i(lut_wr_data),
      .rd_addr_i({rd_bank, raw_data_1}), .rd_data_o(lut1)
   );
   // stage 1 runs alongside the RAM read; stage 2 picks LUT or bit-replicated bypass
   always_ff @(posedge clk) begin
      raw0_q    <= raw_data_0;
      raw1_q    <= raw_data_1;
      use_lut_q <= lut_on_q | swap;
      lin0_q    <= use_lut_q ? lut0 : {raw0_q, raw0_q[DW_IN-1 -: DW_OUT-DW_IN]};
      lin1_q    <= use_lut_q ? lut1 : {raw1_q, raw1_q[DW_IN-1 -: DW_OUT-DW_IN]};
   end
   delay_rg #(.W(3), .D(2)) u_qual (
      .clk_i(clk), .rst_i(reset),
      .d_i({raw_data_valid, raw_data_sop, raw_data_eop}),
      .q_o({lin_data_valid, lin_data_sop, lin_data_eop})
   );
   assign lin_data_0      = lin0_q;
   assign lin_data_1      = lin1_q;
   assign lut_pending     = state_q == PENDING;
   assign lut_active_bank = bank_q;
endmodule

// File: tb/tb_degamma_correction.sv
// tb_degamma_correction: directed self-checking bench for degamma_correction
module tb_degamma_correction;
   logic        clk = 0, reset = 1;
   logic [7:0]  raw_data_0 = 0, raw_data_1 = 0, lut_wr_addr = 0;
   logic        raw_data_valid = 0, raw_data_sop = 0, raw_data_eop = 0;
   logic        lut_wr_en = 0, lut_commit = 0;
   logic [11:0] lut_wr_data = 0;
   logic [11:0] lin_data_0, lin_data_1;
   logic        lin_data_valid, lin_data_sop, lin_data_eop, lut_pending, lut_active_bank;
   int          errors = 0, checks = 0;
   logic [11:0] o0, o1;
   logic        ov, os;

   degamma_correction dut (
      .clk(clk), .reset(reset),
      .raw_data_0(raw_data_0), .raw_data_1(raw_data_1),
      .raw_data_valid(raw_data_valid), .raw_data_sop(raw_data_sop), .raw_data_eop(raw_data_eop),
      .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .lut_commit(lut_commit),
      .lin_data_0(lin_data_0), .lin_data_1(lin_data_1),
      .lin_data_valid(lin_data_valid), .lin_data_sop(lin_data_sop), .lin_data_eop(lin_data_eop),
      .lut_pending(lut_pending), .lut_active_bank(lut_active_bank)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, s, e, c, input logic [7:0] r0, r1);
      raw_data_valid = v; raw_data_sop = s; raw_data_eop = e; lut_commit = c;
      raw_data_0 = r0; raw_data_1 = r1;
   endtask

   // one isolated beat; returns what appears two clocks later
   task automatic beat(input logic s, e, c, input logic [7:0] r0, r1);
      drive(1, s, e, c, r0, r1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      step();
      o0 = lin_data_0; o1 = lin_data_1; ov = lin_data_valid; os = lin_data_sop;
   endtask

   task automatic wr(input logic [7:0] a, input logic [11:0] d);
      lut_wr_en = 1; lut_wr_addr = a; lut_wr_data = d;
      step();
      lut_wr_en = 0;
   endtask

   task automatic load(input logic [11:0] base, input int mul);
      for (int i = 0; i < 256; i++) wr(8'(i), base | 12'(i * mul));
   endtask

   task automatic commit();
      lut_commit = 1;
      step();
      lut_commit = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      step(); step();
      checks++; if (lin_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", lin_data_valid); end
      checks++; if (lut_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", lut_pending); end
      checks++; if (lut_active_bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %b want 0", lut_active_bank); end
      reset = 0;
      step();
   endtask

   task automatic test_bypass();
      beat(1, 0, 0, 8'hAB, 8'h10);
      checks++; if (ov !== 1'b1 || os !== 1'b1) begin errors++; $display("FAIL bypass_qual got v=%b s=%b want 1 1", ov, os); end
      checks++; if (o0 !== 12'hABA) begin errors++; $display("FAIL bypass_px0 got %h want aba", o0); end
      checks++; if (o1 !== 12'h101) begin errors++; $display("FAIL bypass_px1 got %h want 101", o1); end
      checks++; if (lut_active_bank !== 1'b0) begin errors++; $display("FAIL bypass_bank got %b want 0", lut_active_bank); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 0, 0, 8'hFF, 8'h00);
      step();
      checks++; if (lin_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency got valid=%b want 0", lin_data_valid); end
      drive(1, 0, 1, 0, 8'h5C, 8'h81);
      step();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (lin_data_valid !== 1'b1 || lin_data_0 !== 12'hFFF || lin_data_1 !== 12'h000)
         begin errors++; $display("FAIL b2b_first got v=%b %h %h want 1 fff 000", lin_data_valid, lin_data_0, lin_data_1); end
      step();
      checks++; if (lin_data_eop !== 1'b1 || lin_data_0 !== 12'h5C5 || lin_data_1 !== 12'h818)
         begin errors++; $display("FAIL b2b_second got e=%b %h %h want 1 5c5 818", lin_data_eop, lin_data_0, lin_data_1); end
      step();
      checks++; if (lin_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b want 0", lin_data_valid); end
   endtask

   task automatic test_commit_swap();
      load(12'h000, 16);
      commit();
      checks++; if (lut_pending !== 1'b1) begin errors++; $display("FAIL swap_pending got %b want 1", lut_pending); end
      beat(0, 0, 0, 8'h30, 8'h30);
      checks++; if (o0 !== 12'h303) begin errors++; $display("FAIL swap_presop got %h want 303", o0); end
      checks++; if (lut_pending !== 1'b1) begin errors++; $display("FAIL swap_hold got %b want 1", lut_pending); end
      beat(1, 0, 0, 8'h20, 8'h05);
      checks++; if (o0 !== 12'h200 || o1 !== 12'h050) begin errors++; $display("FAIL swap_lut got %h %h want 200 050", o0, o1); end
      checks++; if (lut_pending !== 1'b0 || lut_active_bank !== 1'b1)
         begin errors++; $display("FAIL swap_status got p=%b b=%b want 0 1", lut_pending, lut_active_bank); end
   endtask

   task automatic test_mid_frame_commit();
      load(12'h800, 1);
      beat(1, 0, 0, 8'h11, 8'h00);
      checks++; if (o0 !== 12'h110 || o1 !== 12'h000) begin errors++; $display("FAIL mid_sop got %h %h want 110 000", o0, o1); end
      beat(0, 0, 1, 8'h12, 8'h01);
      checks++; if (o0 !== 12'h120 || o1 !== 12'h010) begin errors++; $display("FAIL mid_commit got %h %h want 120 010", o0, o1); end
      beat(0, 1, 0, 8'h13, 8'h02);
      checks++; if (o0 !== 12'h130 || lut_pending !== 1'b1) begin errors++; $display("FAIL mid_eop got %h p=%b want 130 1", o0, lut_pending); end
      beat(1, 0, 0, 8'h14, 8'h00);
      checks++; if (o0 !== 12'h814 || o1 !== 12'h800) begin errors++; $display("FAIL mid_next got %h %h want 814 800", o0, o1); end
      checks++; if (lut_active_bank !== 1'b0 || lut_pending !== 1'b0)
         begin errors++; $display("FAIL mid_status got b=%b p=%b want 0 0", lut_active_bank, lut_pending); end
   endtask

   task automatic test_commit_on_sop();
      wr(8'h40, 12'h123);
      beat(1, 0, 1, 8'h40, 8'h40);
      checks++; if (o0 !== 12'h840 || lut_pending !== 1'b1) begin errors++; $display("FAIL cos_same got %h p=%b want 840 1", o0, lut_pending); end
      beat(0, 0, 0, 8'h40, 8'h41);
      checks++; if (o0 !== 12'h840 || o1 !== 12'h841) begin errors++; $display("FAIL cos_frame got %h %h want 840 841", o0, o1); end
      beat(1, 0, 0, 8'h40, 8'h41);
      checks++; if (o0 !== 12'h123 || o1 !== 12'h410) begin errors++; $display("FAIL cos_next got %h %h want 123 410", o0, o1); end
      checks++; if (lut_active_bank !== 1'b1) begin errors++; $display("FAIL cos_bank got %b want 1", lut_active_bank); end
   endtask

   task automatic test_write_while_pending();
      wr(8'h20, 12'h200);
      commit();
      wr(8'h20, 12'hFFF);
      beat(1, 0, 0, 8'h20, 8'h21);
      checks++; if (o0 !== 12'h200 || o1 !== 12'h821) begin errors++; $display("FAIL wwp_lut got %h %h want 200 821", o0, o1); end
      checks++; if (lut_active_bank !== 1'b0) begin errors++; $display("FAIL wwp_bank got %b want 0", lut_active_bank); end
   endtask

   task automatic test_reset_in_flight();
      commit();
      beat(1, 0, 0, 8'h50, 8'h40);
      checks++; if (o0 !== 12'h500 || o1 !== 12'h123 || lut_active_bank !== 1'b1)
         begin errors++; $display("FAIL rif_swap got %h %h b=%b want 500 123 1", o0, o1, lut_active_bank); end
      commit();
      drive(1, 0, 0, 0, 8'h33, 8'h33);
      step();
      drive(1, 0, 0, 0, 8'h44, 8'h44);
      step();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1;
      step();
      checks++; if (lin_data_valid !== 1'b0) begin errors++; $display("FAIL rif_valid0 got %b want 0", lin_data_valid); end
      checks++; if (lut_pending !== 1'b0 || lut_active_bank !== 1'b0)
         begin errors++; $display("FAIL rif_status got p=%b b=%b want 0 0", lut_pending, lut_active_bank); end
      step();
      reset = 0;
      step();
      checks++; if (lin_data_valid !== 1'b0) begin errors++; $display("FAIL rif_valid1 got %b want 0", lin_data_valid); end
      beat(1, 0, 0, 8'h5A, 8'hC3);
      checks++; if (ov !== 1'b1 || o0 !== 12'h5A5 || o1 !== 12'hC3C)
         begin errors++; $display("FAIL rif_bypass got v=%b %h %h want 1 5a5 c3c", ov, o0, o1); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_back_to_back();
      test_commit_swap();
      test_mid_frame_commit();
      test_commit_on_sop();
      test_write_while_pending();
      test_reset_in_flight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
